bk_adder_arbiter: RTL and testbench



---
 rtl/bk_adder_arbiter_if.sv | 37 +++
 rtl/bk_adder_arbiter.sv | 146 ++++++++++++++
 tb/tb_bk_adder_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bk_adder_arbiter_if.sv
// Bundle between the client datapaths, the shared external adder and bk_adder_arbiter.
//   master: client/environment side (drives requests, adder result and response ready)
//   slave : arbiter side (drives grants, adder operands and the registered response)
// Signals:
//   req_valid/req_ready  per-requester handshake (ready is one-hot or zero)
//   req_a/req_b          packed operands, requester i at [i*WIDTH +: WIDTH]
//   add_in               interleaved operands to the adder (bit 2k = a[k], 2k+1 = b[k])
//   add_out              adder result, carry-out in bit WIDTH
//   rsp_valid/rsp_ready  response handshake; rsp_sum, rsp_id carry the result and owner
//   ovf_count            saturating count of delivered results with carry-out set
interface bk_adder_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 12,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [2*WIDTH-1:0]       add_in;
  logic [WIDTH:0]           add_out;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH:0]           rsp_sum;
  logic [ID_W-1:0]          rsp_id;
  logic [15:0]              ovf_count;

  modport master (
    output req_valid, req_a, req_b, add_out, rsp_ready,
    input  req_ready, add_in, rsp_valid, rsp_sum, rsp_id, ovf_count
  );

  modport slave (
    input  req_valid, req_a, req_b, add_out, rsp_ready,
    output req_ready, add_in, rsp_valid, rsp_sum, rsp_id, ovf_count
  );
endinterface

// File: rtl/bk_adder_arbiter.sv
// Round-robin arbiter sharing one external combinational adder among NUM_REQ requesters.
// Two-stage pipeline: S1 registers the winner's interleaved operands (driving add_in straight
// from flops), S2 registers add_out together with the owner ID.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    bk_adder_arbiter_if.slave (request, adder and response signals)
module bk_adder_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 12,
  parameter int unsigned ID_W    = 2
) (
  input logic              clk,
  input logic              rst_n,
  bk_adder_arbiter_if.slave bus
);

  // S1 state
  logic               op_valid_q, op_valid_d;
  logic [2*WIDTH-1:0] op_q, op_d;
  logic [ID_W-1:0]    op_id_q, op_id_d;
  // S2 state
  logic               rsp_valid_q, rsp_valid_d;
  logic [WIDTH:0]     rsp_sum_q, rsp_sum_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  // arbitration and statistics
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [15:0]        ovf_q, ovf_d;

  logic               s2_load;
  logic               s1_adv;
  logic               found;
  logic [ID_W-1:0]    idx;
  logic [ID_W-1:0]    win;
  logic [NUM_REQ-1:0] ready;
  logic               xfer;
  logic [WIDTH-1:0]   win_a, win_b;
  logic [2*WIDTH-1:0] win_ilv;

  assign s2_load = !rsp_valid_q || bus.rsp_ready;
  assign s1_adv  = !op_valid_q || s2_load;

  // Search from ptr+1 upward, wrapping modulo NUM_REQ; the first valid requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = ID_W'((32'(ptr_q) + i) % NUM_REQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Grant only while out of reset so req_ready is zero throughout reset.
  always_comb begin
    ready = '0;
    if (found && s1_adv && rst_n) begin
      ready[win] = 1'b1;
    end
  end

  // ready is only ever set on a valid requester, so any ready bit is a transfer.
  assign xfer = |ready;

  always_comb begin
    win_a   = '0;
    win_b   = '0;
    win_ilv = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win == ID_W'(i)) begin
        win_a = bus.req_a[i*WIDTH +: WIDTH];
        win_b = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
    for (int unsigned k = 0; k < WIDTH; k++) begin
      win_ilv[2*k]   = win_a[k];
      win_ilv[2*k+1] = win_b[k];
    end
  end

  always_comb begin
    op_valid_d  = op_valid_q;
    op_d        = op_q;
    op_id_d     = op_id_q;
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_id_d    = rsp_id_q;
    ovf_d       = ovf_q;

    if (xfer) begin
      op_valid_d = 1'b1;
      op_d       = win_ilv;
      op_id_d    = win;
      ptr_d      = win;
    end else if (s2_load) begin
      // S1 content (if any) moves to S2 this cycle and nothing refills it.
      op_valid_d = 1'b0;
    end

    if (s2_load) begin
      rsp_valid_d = op_valid_q;
      if (op_valid_q) begin
        rsp_sum_d = bus.add_out;
        rsp_id_d  = op_id_q;
      end
    end

    if (rsp_valid_q && bus.rsp_ready && rsp_sum_q[WIDTH] && (ovf_q != 16'hFFFF)) begin
      ovf_d = ovf_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid_q  <= 1'b0;
      op_q        <= '0;
      op_id_q     <= '0;
      ptr_q       <= ID_W'(NUM_REQ - 1);
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
      ovf_q       <= '0;
    end else begin
      op_valid_q  <= op_valid_d;
      op_q        <= op_d;
      op_id_q     <= op_id_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_id_q    <= rsp_id_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.add_in    = op_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.ovf_count = ovf_q;

endmodule

// File: tb/tb_bk_adder_arbiter.sv
// Directed bench for bk_adder_arbiter with a behavioural adder, a cycle model of the
// handshakes and a scoreboard of expected responses.
module tb_bk_adder_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned WIDTH   = 12;
  localparam int unsigned ID_W    = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bk_adder_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) bus ();

  bk_adder_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External adder: undo the interleave and add.
  logic [WIDTH-1:0] ad_a, ad_b;
  always_comb begin
    ad_a = '0;
    ad_b = '0;
    for (int k = 0; k < WIDTH; k++) begin
      ad_a[k] = bus.add_in[2*k];
      ad_b[k] = bus.add_in[2*k+1];
    end
  end
  assign bus.add_out = {1'b0, ad_a} + {1'b0, ad_b};

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [WIDTH:0]  sum;
  } rsp_t;

  int checks = 0;
  int errors = 0;
  rsp_t sb[$];
  rsp_t rsp_log[$];
  int   grants[$];

  int               m_ptr;
  bit               m_op, m_rsp;
  logic [15:0]      m_ovf;
  logic [2*WIDTH-1:0] m_add_in;
  int unsigned      req_cnt[NUM_REQ];
  bit               bump;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*WIDTH-1:0] ilv(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] r;
    for (int k = 0; k < WIDTH; k++) begin
      r[2*k]   = a[k];
      r[2*k+1] = b[k];
    end
    return r;
  endfunction

  function automatic int gget(input int j);
    return (j < grants.size()) ? grants[j] : -1;
  endfunction

  function automatic int lid(input int j);
    return (j < rsp_log.size()) ? int'(rsp_log[j].id) : -1;
  endfunction

  task automatic set_ops(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.req_a[i*WIDTH +: WIDTH] = a;
    bus.req_b[i*WIDTH +: WIDTH] = b;
  endtask

  // One clock: check at the falling edge, advance the model, then update stimulus after the
  // rising edge.
  task automatic cycle();
    logic [NUM_REQ-1:0] exp_rdy;
    bit               s2_load, adv, nxt_rsp;
    int               win, acc, idx;
    logic [WIDTH-1:0] a, b;
    rsp_t             e, o;
    @(negedge clk);
    if (!rst_n) begin
      m_op = 0; m_rsp = 0; m_ptr = NUM_REQ - 1; m_ovf = '0; m_add_in = '0;
      sb.delete();
      chk("reset_add_in", 32'(bus.add_in), 32'd0);
    end
    s2_load = !m_rsp || bus.rsp_ready;
    adv     = !m_op || s2_load;
    win = -1;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (m_ptr + i) % NUM_REQ;
      if (win < 0 && bus.req_valid[idx]) win = idx;
    end
    exp_rdy = '0;
    if (win >= 0 && adv && rst_n) exp_rdy[win] = 1'b1;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_rsp));
    chk("ovf_count", 32'(bus.ovf_count), 32'(m_ovf));
    if (m_op) chk("add_in", 32'(bus.add_in), 32'(m_add_in));
    if (m_rsp) begin
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 32'(sb.size()), 32'd1);
      end else begin
        e = sb[0];
        chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
        chk("rsp_sum", 32'(bus.rsp_sum), 32'(e.sum));
        if (bus.rsp_ready) begin
          void'(sb.pop_front());
          o.id  = bus.rsp_id;
          o.sum = bus.rsp_sum;
          rsp_log.push_back(o);
          if (e.sum[WIDTH] && m_ovf != 16'hFFFF) m_ovf = m_ovf + 16'd1;
        end
      end
    end
    nxt_rsp = s2_load ? m_op : m_rsp;
    acc = -1;
    if (exp_rdy != '0) begin
      acc   = win;
      a     = bus.req_a[win*WIDTH +: WIDTH];
      b     = bus.req_b[win*WIDTH +: WIDTH];
      e.id  = ID_W'(win);
      e.sum = {1'b0, a} + {1'b0, b};
      sb.push_back(e);
      m_add_in = ilv(a, b);
      m_ptr = win;
      m_op  = 1;
      grants.push_back(win);
    end else if (s2_load) begin
      m_op = 0;
    end
    m_rsp = nxt_rsp;
    @(posedge clk);
    #1;
    if (acc >= 0) begin
      req_cnt[acc]--;
      bus.req_valid[acc] = (req_cnt[acc] != 0);
      if (bump) begin
        bus.req_a[acc*WIDTH +: WIDTH] = bus.req_a[acc*WIDTH +: WIDTH] + 12'h111;
        bus.req_b[acc*WIDTH +: WIDTH] = bus.req_b[acc*WIDTH +: WIDTH] + 12'h0A5;
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b1;
    bump = 0;
    m_ptr = NUM_REQ - 1; m_op = 0; m_rsp = 0; m_ovf = '0; m_add_in = '0;
    #1 rst_n = 1'b0;

    // Reset with everyone requesting, then requester 0 must win first.
    for (int i = 0; i < NUM_REQ; i++) begin
      set_ops(i, WIDTH'(i), 12'h001);
      req_cnt[i] = 1;
    end
    bus.req_valid = '1;
    repeat (3) cycle();
    rst_n = 1'b1;
    grants.delete();
    cycle();
    chk("first_grant", 32'(gget(0)), 32'd0);
    repeat (6) cycle();

    // Single overflowing add from requester 2.
    set_ops(2, 12'hFFF, 12'h001);
    req_cnt[2] = 1;
    bus.req_valid[2] = 1'b1;
    cycle();
    cycle();
    chk("single_valid", 32'(bus.rsp_valid), 32'd1);
    chk("single_sum", 32'(bus.rsp_sum), 32'h1000);
    chk("single_id", 32'(bus.rsp_id), 32'd2);
    cycle();
    chk("single_ovf", 32'(bus.ovf_count), 32'd1);
    repeat (2) cycle();

    // Round-robin with all four requesters; last grant was 2, so order starts at 3.
    bump = 1;
    set_ops(0, 12'h123, 12'h456);
    set_ops(1, 12'hFFF, 12'hFFF);
    set_ops(2, 12'h0AA, 12'h055);
    set_ops(3, 12'h800, 12'h7FF);
    for (int i = 0; i < NUM_REQ; i++) req_cnt[i] = 3;
    bus.req_valid = '1;
    grants.delete();
    rsp_log.delete();
    repeat (16) cycle();
    chk("rr_grant_count", 32'(grants.size()), 32'd12);
    chk("rr_rsp_count", 32'(rsp_log.size()), 32'd12);
    for (int j = 0; j < 12; j++) begin
      chk("rr_grant_order", 32'(gget(j)), 32'((3 + j) % 4));
      chk("rr_rsp_order", 32'(lid(j)), 32'((3 + j) % 4));
    end
    chk("rr_sum_579", 32'((rsp_log.size() > 1) ? rsp_log[1].sum : 13'h1FFF), 32'h0579);

    // Backpressure with requesters 1 and 3.
    set_ops(1, 12'h321, 12'h0F0);
    set_ops(3, 12'h444, 12'h555);
    req_cnt[1] = 2;
    req_cnt[3] = 2;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1010;
    grants.delete();
    rsp_log.delete();
    repeat (5) cycle();
    chk("bp_accepts", 32'(grants.size()), 32'd2);
    chk("bp_first", 32'(gget(0)), 32'd3);
    chk("bp_second", 32'(gget(1)), 32'd1);
    chk("bp_ready_zero", 32'(bus.req_ready), 32'd0);
    chk("bp_no_rsp", 32'(rsp_log.size()), 32'd0);
    bus.rsp_ready = 1'b1;
    repeat (8) cycle();
    chk("bp_total_grants", 32'(grants.size()), 32'd4);
    chk("bp_total_rsp", 32'(rsp_log.size()), 32'd4);
    chk("bp_rsp0", 32'(lid(0)), 32'd3);
    chk("bp_rsp1", 32'(lid(1)), 32'd1);
    chk("bp_rsp2", 32'(lid(2)), 32'd3);
    chk("bp_rsp3", 32'(lid(3)), 32'd1);

    // Saturation of the overflow counter.
    bump = 0;
    set_ops(0, 12'h800, 12'h800);
    req_cnt[0] = 65540;
    bus.req_valid[0] = 1'b1;
    grants.delete();
    rsp_log.delete();
    repeat (65545) cycle();
    chk("sat_ovf", 32'(bus.ovf_count), 32'hFFFF);
    chk("sat_grants", 32'(grants.size()), 32'd65540);

    // Reset with both stages full.
    set_ops(2, 12'h100, 12'h200);
    req_cnt[2] = 3;
    bus.rsp_ready = 1'b0;
    bus.req_valid[2] = 1'b1;
    repeat (3) cycle();
    chk("mid_full", 32'(bus.rsp_valid), 32'd1);
    rst_n = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) req_cnt[i] = 1;
    bus.req_valid = '1;
    repeat (2) cycle();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    chk("mid_ovf_clear", 32'(bus.ovf_count), 32'd0);
    chk("mid_no_stale", 32'(bus.rsp_valid), 32'd0);
    grants.delete();
    rsp_log.delete();
    repeat (8) cycle();
    chk("mid_first_grant", 32'(gget(0)), 32'd0);
    chk("mid_first_rsp", 32'(lid(0)), 32'd0);
    chk("mid_rsp_count", 32'(rsp_log.size()), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
